// File: rtl/csr_intr_ctrl.sv
// Machine-mode CSR file (mstatus/mie/mip/mtvec/mepc/mcause) with a prioritised interrupt requester.
// Latency: irq lines reach mip after SYNC_STAGES cycles; CSR writes and trap/mret updates land on the next edge.
// Backpressure: intr_req holds until the pipeline acks; an ack without a request is ignored.
module csr_intr_ctrl #(
    parameter int          DW          = 32,
    parameter int          NUM_LOCAL   = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    localparam int         LW          = (NUM_LOCAL > 0) ? NUM_LOCAL : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_csr_we,
    input  logic [11:0]   i_csr_addr,
    input  logic [DW-1:0] i_csr_wdata,
    output logic [DW-1:0] o_csr_rdata,
    input  logic          i_timer_irq,
    input  logic          i_ext_irq,
    input  logic [LW-1:0] i_local_irq,
    output logic          o_intr_req,
    output logic [DW-1:0] o_intr_vec,
    input  logic          i_intr_ack,
    input  logic [DW-1:0] i_epc_in,
    input  logic          i_mret,
    output logic [DW-1:0] o_mepc_out
);

    localparam int          NLINES   = NUM_LOCAL + 2;
    localparam logic [31:0] LOC_MASK = ((32'd1 << NUM_LOCAL) - 32'd1) << 16;
    localparam logic [31:0] MIE_MASK = 32'h0000_0880 | LOC_MASK;

    // Architectural state
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [NLINES-1:0] r_sync [SYNC_STAGES];

    logic [NLINES-1:0] w_irq_in;
    logic [31:0]       w_mip;
    logic [31:0]       w_pend;
    logic [31:0]       w_mstatus;
    logic [4:0]        w_code;
    logic [31:0]       w_base;
    logic              w_take;
    logic              w_wr_mstatus;
    logic              w_wr_mie;
    logic              w_wr_mtvec;
    logic              w_wr_mepc;
    logic              w_wr_mcause;

    // Gather the raw interrupt lines: bit 0 timer, bit 1 external, then locals
    always_comb begin
        w_irq_in    = '0;
        w_irq_in[0] = i_timer_irq;
        w_irq_in[1] = i_ext_irq;
        for (int i = 0; i < NUM_LOCAL; i++) begin
            w_irq_in[2+i] = i_local_irq[i];
        end
    end

    // Synchroniser chain; the last stage is the mip pending state itself
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= w_irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Map synchronised lines onto their mip bit positions
    always_comb begin
        w_mip     = '0;
        w_mip[7]  = r_sync[SYNC_STAGES-1][0];
        w_mip[11] = r_sync[SYNC_STAGES-1][1];
        for (int i = 0; i < NUM_LOCAL; i++) begin
            w_mip[16+i] = r_sync[SYNC_STAGES-1][2+i];
        end
    end

    assign w_pend = w_mip & r_mie;

    // Fixed priority: MEI, then MTI, then local[0] upward (lowest index wins)
    always_comb begin
        w_code = 5'd0;
        for (int i = NUM_LOCAL - 1; i >= 0; i--) begin
            if (w_pend[16+i]) begin
                w_code = 5'(16 + i);
            end
        end
        if (w_pend[7]) begin
            w_code = 5'd7;
        end
        if (w_pend[11]) begin
            w_code = 5'd11;
        end
    end

    assign o_intr_req = r_mstatus_mie & (|w_pend);
    assign w_base     = {r_mtvec[31:2], 2'b00};
    assign o_intr_vec = w_base + (r_mtvec[0] ? {25'd0, w_code, 2'b00} : 32'd0);
    assign o_mepc_out = r_mepc;

    assign w_take       = i_intr_ack & o_intr_req;
    assign w_wr_mstatus = i_csr_we && (i_csr_addr == 12'h300);
    assign w_wr_mie     = i_csr_we && (i_csr_addr == 12'h304);
    assign w_wr_mtvec   = i_csr_we && (i_csr_addr == 12'h305);
    assign w_wr_mepc    = i_csr_we && (i_csr_addr == 12'h341);
    assign w_wr_mcause  = i_csr_we && (i_csr_addr == 12'h342);

    // mstatus: trap entry beats mret, which beats a software write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
        end else if (w_take) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (i_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
            r_mstatus_mie  <= i_csr_wdata[3];
            r_mstatus_mpie <= i_csr_wdata[7];
        end
    end

    // mie and mtvec writes are independent of trap entry
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mie   <= '0;
            r_mtvec <= RESET_VEC;
        end else begin
            if (w_wr_mie) begin
                r_mie <= i_csr_wdata & MIE_MASK;
            end
            if (w_wr_mtvec) begin
                r_mtvec <= i_csr_wdata & ~32'h0000_0002;
            end
        end
    end

    // mepc/mcause: trap entry captures PC and cause, dropping a same-cycle write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mepc   <= '0;
            r_mcause <= '0;
        end else if (w_take) begin
            r_mepc   <= i_epc_in & ~32'h0000_0003;
            r_mcause <= {1'b1, 26'd0, w_code};
        end else begin
            if (w_wr_mepc) begin
                r_mepc <= i_csr_wdata & ~32'h0000_0003;
            end
            if (w_wr_mcause) begin
                r_mcause <= i_csr_wdata;
            end
        end
    end

    assign w_mstatus = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};

    // Combinational read port straight from current register state
    always_comb begin
        o_csr_rdata = '0;
        case (i_csr_addr)
            12'h300: o_csr_rdata = w_mstatus;
            12'h304: o_csr_rdata = r_mie;
            12'h305: o_csr_rdata = r_mtvec;
            12'h341: o_csr_rdata = r_mepc;
            12'h342: o_csr_rdata = r_mcause;
            12'h344: o_csr_rdata = w_mip;
            default: o_csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_intr_ctrl.sv
// Bench for csr_intr_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared with a cycle-level reference model of the CSR/interrupt rules.
// Inputs change on the falling edge; outputs are sampled 1ns after that.
module tb_csr_intr_ctrl;

    localparam int          NL = 4;
    localparam int          SS = 2;
    localparam logic [31:0] RV = 32'h8000_0101;
    localparam logic [31:0] MIE_MSK = 32'h000F_0880;

    logic        clk;
    logic        i_rst;
    logic        i_csr_we;
    logic [11:0] i_csr_addr;
    logic [31:0] i_csr_wdata;
    logic [31:0] o_csr_rdata;
    logic        i_timer_irq;
    logic        i_ext_irq;
    logic [NL-1:0] i_local_irq;
    logic        o_intr_req;
    logic [31:0] o_intr_vec;
    logic        i_intr_ack;
    logic [31:0] i_epc_in;
    logic        i_mret;
    logic [31:0] o_mepc_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
    logic [NL+1:0] hist [$];

    logic [11:0] addrs [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h123};

    csr_intr_ctrl #(
        .DW(32), .NUM_LOCAL(NL), .SYNC_STAGES(SS), .RESET_VEC(RV)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_csr_we(i_csr_we), .i_csr_addr(i_csr_addr),
        .i_csr_wdata(i_csr_wdata), .o_csr_rdata(o_csr_rdata),
        .i_timer_irq(i_timer_irq), .i_ext_irq(i_ext_irq), .i_local_irq(i_local_irq),
        .o_intr_req(o_intr_req), .o_intr_vec(o_intr_vec), .i_intr_ack(i_intr_ack),
        .i_epc_in(i_epc_in), .i_mret(i_mret), .o_mepc_out(o_mepc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mip is the input level seen SS edges ago
    function automatic logic [31:0] m_mip();
        logic [NL+1:0] v;
        logic [31:0]   m;
        v = hist[SS-1];
        m = 32'd0;
        m[7]  = v[0];
        m[11] = v[1];
        for (int i = 0; i < NL; i++) m[16+i] = v[2+i];
        return m;
    endfunction

    function automatic int m_code();
        logic [31:0] p;
        p = m_mip() & m_mie;
        if (p[11]) return 11;
        if (p[7]) return 7;
        for (int i = 0; i < NL; i++) if (p[16+i]) return 16 + i;
        return 0;
    endfunction

    function automatic logic m_req();
        return m_mstatus[3] && ((m_mip() & m_mie) != 32'd0);
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] base;
        base = m_mtvec & ~32'd3;
        return m_mtvec[0] ? base + 32'(m_code() * 4) : base;
    endfunction

    function automatic logic [31:0] m_rd(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip();
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset_hist();
        hist.delete();
        for (int s = 0; s < SS; s++) hist.push_back('0);
    endtask

    // Advance the model by one clock edge using the inputs held this cycle
    task automatic m_update();
        logic        take;
        int          code;
        logic [31:0] ms;
        if (i_rst) begin
            m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0; m_mtvec = RV;
            m_reset_hist();
            return;
        end
        take = i_intr_ack && m_req();
        code = m_code();
        ms   = m_mstatus;
        if (take) begin
            m_mstatus = (ms[3] ? 32'h80 : 32'h0);
            m_mepc    = i_epc_in & ~32'd3;
            m_mcause  = 32'h8000_0000 | 32'(code);
        end else begin
            if (i_mret) m_mstatus = 32'h80 | (ms[7] ? 32'h8 : 32'h0);
            else if (i_csr_we && i_csr_addr == 12'h300) m_mstatus = i_csr_wdata & 32'h88;
            if (i_csr_we && i_csr_addr == 12'h341) m_mepc = i_csr_wdata & ~32'd3;
            if (i_csr_we && i_csr_addr == 12'h342) m_mcause = i_csr_wdata;
        end
        if (i_csr_we && i_csr_addr == 12'h304) m_mie = i_csr_wdata & MIE_MSK;
        if (i_csr_we && i_csr_addr == 12'h305) m_mtvec = i_csr_wdata & ~32'd2;
        hist.push_front({i_local_irq, i_ext_irq, i_timer_irq});
        void'(hist.pop_back());
    endtask

    // Compare outputs with the model, then take one clock edge
    task automatic tick();
        #1;
        chk("req", {31'd0, o_intr_req}, {31'd0, m_req()});
        chk("vec", o_intr_vec, m_vec());
        chk("rdata", o_csr_rdata, m_rd(i_csr_addr));
        chk("mepc_out", o_mepc_out, m_mepc);
        @(posedge clk);
        m_update();
        @(negedge clk);
        i_csr_we = 1'b0; i_intr_ack = 1'b0; i_mret = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        i_csr_we = 1'b1; i_csr_addr = a; i_csr_wdata = d;
        tick();
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        i_csr_addr = a;
        #1;
        chk(tag, o_csr_rdata, exp);
    endtask

    initial begin
        i_rst = 1'b1; i_csr_we = 1'b0; i_csr_addr = 12'h0; i_csr_wdata = 0;
        i_timer_irq = 0; i_ext_irq = 0; i_local_irq = '0;
        i_intr_ack = 0; i_epc_in = 0; i_mret = 0;
        m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0; m_mtvec = RV;
        m_reset_hist();
        @(negedge clk);
        tick(); tick();
        i_rst = 1'b0;

        // Reset state
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_mtvec", 12'h305, RV);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        rd("rst_mip", 12'h344, 32'h0);
        chk("rst_req", {31'd0, o_intr_req}, 32'd0);
        chk("rst_vec", o_intr_vec, RV & ~32'd3);

        wr(12'h300, 32'hFFFF_FFFF);
        rd("mstatus_mask", 12'h300, 32'h88);

        // Timer interrupt latency and vector modes
        wr(12'h305, 32'h1000);
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        i_timer_irq = 1'b1;
        tick();
        chk("tmr_lat_early", {31'd0, o_intr_req}, 32'd0);
        tick();
        chk("tmr_lat_req", {31'd0, o_intr_req}, 32'd1);
        chk("tmr_vec_direct", o_intr_vec, 32'h1000);
        wr(12'h305, 32'h1001);
        chk("tmr_vec_vectored", o_intr_vec, 32'h101C);

        // Trap entry then mret
        i_intr_ack = 1'b1; i_epc_in = 32'h246;
        tick();
        chk("ack_mepc_out", o_mepc_out, 32'h244);
        chk("ack_req_drop", {31'd0, o_intr_req}, 32'd0);
        rd("ack_mcause", 12'h342, 32'h8000_0007);
        rd("ack_mstatus", 12'h300, 32'h80);
        i_mret = 1'b1;
        tick();
        rd("mret_mstatus", 12'h300, 32'h88);

        // Priority among simultaneous sources
        i_ext_irq = 1'b1; i_local_irq = 4'b0101;
        wr(12'h304, 32'h000F_0880);
        wr(12'h305, 32'h2001);
        tick();
        chk("prio_vec_mei", o_intr_vec, 32'h202C);
        i_intr_ack = 1'b1; tick();
        rd("prio_cause_mei", 12'h342, 32'h8000_000B);
        i_mret = 1'b1; tick();
        wr(12'h304, 32'h000F_0080);
        chk("prio_vec_mti", o_intr_vec, 32'h201C);
        i_intr_ack = 1'b1; tick();
        rd("prio_cause_mti", 12'h342, 32'h8000_0007);
        i_mret = 1'b1; tick();
        wr(12'h304, 32'h0004_0000);
        chk("prio_vec_l2", o_intr_vec, 32'h2048);
        i_intr_ack = 1'b1; tick();
        rd("prio_cause_l2", 12'h342, 32'h8000_0012);
        i_mret = 1'b1; tick();

        // ack + mret + mstatus write in one cycle
        rd("coll_pre", 12'h300, 32'h88);
        i_intr_ack = 1'b1; i_mret = 1'b1; i_epc_in = 32'h1234_5678;
        i_csr_we = 1'b1; i_csr_addr = 12'h300; i_csr_wdata = 32'h0;
        tick();
        rd("coll_mstatus", 12'h300, 32'h80);
        rd("coll_mcause", 12'h342, 32'h8000_0012);
        chk("coll_mepc", o_mepc_out, 32'h1234_5678);

        // One-cycle timer pulse with interrupts globally disabled
        wr(12'h300, 32'h0);
        wr(12'h304, 32'h80);
        i_timer_irq = 0; i_ext_irq = 0; i_local_irq = '0;
        tick(); tick(); tick();
        i_timer_irq = 1'b1; tick();
        i_timer_irq = 1'b0; tick();
        rd("pulse_mip_hi", 12'h344, 32'h80);
        chk("pulse_req", {31'd0, o_intr_req}, 32'd0);
        tick();
        rd("pulse_mip_lo", 12'h344, 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            i_rst       = ($urandom_range(0, 79) == 0);
            i_csr_we    = ($urandom_range(0, 2) == 0);
            i_csr_addr  = addrs[$urandom_range(0, 6)];
            i_csr_wdata = $urandom;
            i_intr_ack  = ($urandom_range(0, 2) == 0);
            i_mret      = ($urandom_range(0, 5) == 0);
            i_epc_in    = $urandom;
            if ($urandom_range(0, 5) == 0) i_timer_irq = ~i_timer_irq;
            if ($urandom_range(0, 5) == 0) i_ext_irq = ~i_ext_irq;
            if ($urandom_range(0, 3) == 0) i_local_irq = NL'($urandom);
            tick();
        end
        i_rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csr_intr_ctrl.md
Name: csr_intr_ctrl

Overview:
- Machine-mode CSR file plus interrupt controller for the 3-stage core.
- Holds mstatus, mie, mip, mtvec, mepc and mcause.
- Synchronises and prioritises timer, external and NUM_LOCAL platform interrupt lines, then raises a request with a vector to the fetch stage.
- Performs trap-entry and mret state updates through a request/acknowledge handshake with the pipeline.

Parameters:
DW, 32, data width of CSRs and PCs (only 32 supported)
NUM_LOCAL, 4, number of local interrupt lines, 0..16, mapped to mip/mie bits 16..16+NUM_LOCAL-1
SYNC_STAGES, 2, flop stages on each interrupt input, 1..3
RESET_VEC, 32'h0000_0000, mtvec reset value

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
csr_we  in  1  CSR write strobe
csr_addr  in  12  CSR address for read and write
csr_wdata  in  DW  CSR write data
csr_rdata  out  DW  combinational read data for csr_addr
timer_irq  in  1  level timer interrupt (MTIP, bit 7)
ext_irq  in  1  level external interrupt (MEIP, bit 11)
local_irq  in  NUM_LOCAL  level local interrupts (bit 16+i)
intr_req  out  1  interrupt pending and globally enabled
intr_vec  out  DW  trap target PC for the winning interrupt
intr_ack  in  1  pipeline takes the trap this cycle
epc_in  in  DW  PC to be saved in mepc on intr_ack
mret  in  1  mret retiring this cycle
mepc_out  out  DW  current mepc, return target for mret

Behaviour:
- Reset (rst=1 at edge):
  - mstatus=0, mie=0, mip=0, mepc=0, mcause=0, mtvec=RESET_VEC.
  - Sync flops are cleared.
  - intr_req=0, intr_vec=RESET_VEC & ~3.
  - rst mid-trap discards any pending ack/mret.
- CSR map:
  - 0x300 mstatus: only bit 3 (MIE) and bit 7 (MPIE) are writable; other bits read 0.
  - 0x304 mie: only bits 7, 11 and 16..16+NUM_LOCAL-1 are writable; others read 0.
  - 0x305 mtvec: bit 1 is forced 0 on write.
  - 0x341 mepc: bits [1:0] are forced 0.
  - 0x342 mcause: fully writable.
  - 0x344 mip: read-only; writes are ignored.
  - Any other address reads 0 and ignores writes.
- Writes take effect at the next edge. csr_rdata is combinational from current register state, with no write bypass.
- Input path:
  - Each irq line passes through SYNC_STAGES flops, then into the mip bit.
  - mip reflects an input level SYNC_STAGES cycles after it is applied.
  - Deassertion follows with the same latency; there is no latching, all lines are level.
- Pending: pend = mip & mie. Fixed priority, MEI(11) > MTI(7) > local[0] > ... > local[NUM_LOCAL-1]. Winning code is 11, 7 or 16+i.
- intr_req = mstatus.MIE & |pend, combinational from registered state.
- intr_vec:
  - base = {mtvec[31:2], 2'b00}.
  - mtvec[0]=1 (vectored): base + (code << 2).
  - Otherwise (direct): base.
  - Arithmetic is mod 2^32; wrap is allowed.
- Trap entry, on intr_ack=1 while intr_req=1:
  - mepc <= {epc_in[31:2], 2'b00}
  - mcause <= {1'b1, 31'(code)}
  - MPIE <= MIE; MIE <= 0
  - intr_req drops the following cycle.
- intr_ack while intr_req=0 is ignored, with no state change.
- mret=1: MIE <= MPIE, MPIE <= 1. mepc_out = mepc, unchanged.
- Simultaneous events, same cycle:
  - intr_ack beats mret: mret is ignored.
  - intr_ack beats a csr_we to mstatus, mepc or mcause: the write is dropped.
  - csr_we to mie or mtvec proceeds together with the ack.
  - mret beats a csr_we to mstatus.
- The vector and cause are those evaluated in the ack cycle, even if pend changes that same cycle.

Test Plan:
- Reset then read all six CSRs -> 0 except mtvec=RESET_VEC; intr_req=0; write 0xFFFF_FFFF to mstatus -> reads 0x0000_0088.
- mtvec=0x0000_1000, mie=0x80, mstatus=0x8; raise timer_irq at cycle t -> intr_req=1 at t+SYNC_STAGES, intr_vec=0x1000; set mtvec=0x1001 -> intr_vec=0x101C.
- With the previous setup, ack with epc_in=0x0000_0246 -> mepc=0x244, mcause=0x8000_0007, mstatus=0x80, intr_req=0 next cycle; then mret -> mstatus=0x88.
- timer_irq, ext_irq and local_irq[0] all high, all enabled, vectored with base 0x2000 -> intr_vec=0x202C, cause 11 on ack; with mie[11]=0 -> cause 7; with only local[2] enabled -> cause 18, intr_vec=0x2048.
- intr_ack, mret and csr_we (mstatus=0) in the same cycle with MIE=1 -> trap entry only: mstatus=0x80, mcause set, mret and write dropped.
- Pulse timer_irq for one cycle with mstatus.MIE=0 -> mip[7] high for one cycle after latency, intr_req stays 0, mip then reads 0.
